// File: rtl/sram_bus_ctrl_pkg.sv
// rtl/sram_bus_ctrl_pkg.sv - shared state encoding and default wait-cycle constants for sram_bus_ctrl
package sram_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RMW_RD,
        WRITE,
        DONE
    } state_t;

    localparam int unsigned CNT_W              = 3;
    localparam int unsigned DEF_RD_LATENCY     = 1;
    localparam int unsigned DEF_WR_LATENCY     = 1;
    localparam int unsigned DEF_RMW_RD_LATENCY = 1;
    localparam int unsigned DEF_RMW_WR_LATENCY = 1;

endpackage

// File: rtl/sram_be_merge.sv
// rtl/sram_be_merge.sv - per-byte merge of new write data over old SRAM data
module sram_be_merge (
    input  logic [3:0]  be,
    input  logic [31:0] new_data,
    input  logic [31:0] old_data,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_data;
        for (int n = 0; n < 4; n++) begin
            if (be[n]) begin
                merged[8*n +: 8] = new_data[8*n +: 8];
            end
        end
    end

endmodule

// File: rtl/sram_bus_ctrl.sv
// rtl/sram_bus_ctrl.sv - CPU-to-async-SRAM bus controller with read-modify-write for partial writes
// Optional feature macro: POSTED_WRITE_EN (acknowledge full-word writes on entry to WRITE).
module sram_bus_ctrl
    import sram_bus_ctrl_pkg::*;
#(
    parameter int unsigned RD_LATENCY     = DEF_RD_LATENCY,
    parameter int unsigned WR_LATENCY     = DEF_WR_LATENCY,
    parameter int unsigned RMW_RD_LATENCY = DEF_RMW_RD_LATENCY,
    parameter int unsigned RMW_WR_LATENCY = DEF_RMW_WR_LATENCY
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        sel,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [18:0] io_a,
    input  logic [3:0]  io_be,
    input  logic [31:0] io_di,
    output logic [31:0] io_q,
    output logic        io_ready,
    output logic        ram_cs,
    output logic        ram_oe,
    output logic        ram_wr,
    output logic        ram_ub_b,
    output logic        ram_lb_b,
    output logic [18:0] ram_addr,
    output logic [31:0] ram_dout,
    output logic        ram_doe,
    input  logic [31:0] ram_din
);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [31:0]        io_q_d, dout_d, di_q, di_d, merged;
    logic [3:0]         be_q, be_d;
    logic [18:0]        addr_d;
    logic               ready_d, cs_d, oe_d, wr_d, ub_d, lb_d, doe_d;
`ifdef POSTED_WRITE_EN
    logic               posted_q, posted_d;
`endif

    // Write data and enables are latched at accept so a dropped request still merges correctly.
    sram_be_merge u_merge (
        .be       (be_q),
        .new_data (di_q),
        .old_data (ram_din),
        .merged   (merged)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        io_q_d  = io_q;
        ready_d = 1'b0;
        cs_d    = ram_cs;
        oe_d    = ram_oe;
        wr_d    = ram_wr;
        ub_d    = ram_ub_b;
        lb_d    = ram_lb_b;
        addr_d  = ram_addr;
        dout_d  = ram_dout;
        doe_d   = ram_doe;
        di_d    = di_q;
        be_d    = be_q;
`ifdef POSTED_WRITE_EN
        posted_d = posted_q;
`endif
        case (state)
            IDLE: begin
                cs_d  = 1'b1;
                oe_d  = 1'b1;
                wr_d  = 1'b1;
                doe_d = 1'b0;
                if (sel && (io_rd || io_wr)) begin
                    addr_d = io_a;
                    ub_d   = 1'b0;
                    lb_d   = 1'b0;
                    cs_d   = 1'b0;
                    di_d   = io_di;
                    be_d   = io_be;
                    if (io_rd || io_be != 4'b1111) begin
                        oe_d    = 1'b0;
                        state_d = io_rd ? READ : RMW_RD;
                        cnt_d   = io_rd ? CNT_W'(RD_LATENCY) : CNT_W'(RMW_RD_LATENCY);
                    end else begin
                        wr_d    = 1'b0;
                        doe_d   = 1'b1;
                        dout_d  = io_di;
                        state_d = WRITE;
                        cnt_d   = CNT_W'(WR_LATENCY);
`ifdef POSTED_WRITE_EN
                        ready_d  = 1'b1;
                        posted_d = 1'b1;
`endif
                    end
                end
            end
            READ: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    io_q_d  = ram_din;
                    cs_d    = 1'b1;
                    oe_d    = 1'b1;
                    wr_d    = 1'b1;
                    ub_d    = 1'b1;
                    lb_d    = 1'b1;
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            RMW_RD: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    dout_d  = merged;
                    cs_d    = 1'b0;
                    oe_d    = 1'b1;
                    wr_d    = 1'b0;
                    doe_d   = 1'b1;
                    cnt_d   = CNT_W'(RMW_WR_LATENCY);
                    state_d = WRITE;
`ifdef POSTED_WRITE_EN
                    posted_d = 1'b0;
`endif
                end
            end
            WRITE: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    cs_d    = 1'b1;
                    oe_d    = 1'b1;
                    wr_d    = 1'b1;
                    ub_d    = 1'b1;
                    lb_d    = 1'b1;
                    doe_d   = 1'b0;
                    state_d = DONE;
`ifdef POSTED_WRITE_EN
                    ready_d = !posted_q;
`else
                    ready_d = 1'b1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state    <= IDLE;
            cnt      <= '0;
            io_q     <= '0;
            io_ready <= 1'b0;
            ram_cs   <= 1'b1;
            ram_oe   <= 1'b1;
            ram_wr   <= 1'b1;
            ram_ub_b <= 1'b1;
            ram_lb_b <= 1'b1;
            ram_addr <= '0;
            ram_dout <= '0;
            ram_doe  <= 1'b0;
            di_q     <= '0;
            be_q     <= '0;
`ifdef POSTED_WRITE_EN
            posted_q <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            io_q     <= io_q_d;
            io_ready <= ready_d;
            ram_cs   <= cs_d;
            ram_oe   <= oe_d;
            ram_wr   <= wr_d;
            ram_ub_b <= ub_d;
            ram_lb_b <= lb_d;
            ram_addr <= addr_d;
            ram_dout <= dout_d;
            ram_doe  <= doe_d;
            di_q     <= di_d;
            be_q     <= be_d;
`ifdef POSTED_WRITE_EN
            posted_q <= posted_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// tb/tb_sram_bus_ctrl.sv - scoreboard bench for sram_bus_ctrl with behavioural SRAM and reference memory
module tb_sram_bus_ctrl;
    import sram_bus_ctrl_pkg::*;

    localparam int RD = 1;
    localparam int WR = 1;
    localparam int RR = 1;
    localparam int RW = 1;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        int          e0;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_b, sel, io_rd, io_wr;
    logic [18:0] io_a;
    logic [3:0]  io_be;
    logic [31:0] io_di, io_q, ram_dout, ram_din;
    logic        io_ready, ram_cs, ram_oe, ram_wr, ram_ub_b, ram_lb_b, ram_doe;
    logic [18:0] ram_addr;

    logic        sel2, rd2, wr2;
    logic [18:0] a2;
    logic [3:0]  be2;
    logic [31:0] di2, q2, dout2;
    logic [31:0] din2 = 32'h55AA55AA;
    logic        ready2, cs2, oe2, wrs2, ub2, lb2, doe2;
    logic [18:0] addr2;

    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];
    exp_t        exp_q [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_bus_ctrl #(.RD_LATENCY(RD), .WR_LATENCY(WR), .RMW_RD_LATENCY(RR), .RMW_WR_LATENCY(RW)) dut (
        .clk(clk), .rst_b(rst_b), .sel(sel), .io_rd(io_rd), .io_wr(io_wr), .io_a(io_a),
        .io_be(io_be), .io_di(io_di), .io_q(io_q), .io_ready(io_ready), .ram_cs(ram_cs),
        .ram_oe(ram_oe), .ram_wr(ram_wr), .ram_ub_b(ram_ub_b), .ram_lb_b(ram_lb_b),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_doe(ram_doe), .ram_din(ram_din)
    );

    sram_bus_ctrl #(.RD_LATENCY(0), .WR_LATENCY(2), .RMW_RD_LATENCY(7), .RMW_WR_LATENCY(7)) dut2 (
        .clk(clk), .rst_b(rst_b), .sel(sel2), .io_rd(rd2), .io_wr(wr2), .io_a(a2),
        .io_be(be2), .io_di(di2), .io_q(q2), .io_ready(ready2), .ram_cs(cs2),
        .ram_oe(oe2), .ram_wr(wrs2), .ram_ub_b(ub2), .ram_lb_b(lb2),
        .ram_addr(addr2), .ram_dout(dout2), .ram_doe(doe2), .ram_din(din2)
    );

    // Behavioural asynchronous SRAM: combinational read, write captured while strobed.
    assign ram_din = mem[ram_addr[4:0]];
    always @(posedge clk) begin
        if (!rst_b) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (!ram_cs && !ram_wr && ram_doe) begin
            mem[ram_addr[4:0]] <= ram_dout;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [31:0] merge_ref(input logic [31:0] old_d, input logic [31:0] new_d,
                                              input logic [3:0] be);
        logic [31:0] r;
        r = old_d;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_d[8*b +: 8];
        return r;
    endfunction

    // Issues one transaction from a negedge, drops the request after accept, and watches the SRAM strobes.
    task automatic txn(input bit rd, input logic [18:0] a, input logic [3:0] be, input logic [31:0] di,
                       output logic [31:0] dout_seen);
        exp_t        e;
        int          oe_want, wr_want, oe_n, wr_n, doe_bad;
        logic [31:0] dout_want;
        oe_n = 0; wr_n = 0; doe_bad = 0; dout_seen = '0; dout_want = '0;
        e.is_rd = rd;
        e.data  = ref_mem[a[4:0]];
        e.e0    = cyc + 1;
        if (rd) begin
            e.lat = RD + 1; oe_want = RD + 1; wr_want = 0;
        end else if (be == 4'hF) begin
`ifdef POSTED_WRITE_EN
            e.lat = 1;
`else
            e.lat = WR + 1;
`endif
            oe_want = 0; wr_want = WR + 1; dout_want = di;
            ref_mem[a[4:0]] = di;
        end else begin
            e.lat = RR + RW + 2; oe_want = RR + 1; wr_want = RW + 1;
            dout_want = merge_ref(ref_mem[a[4:0]], di, be);
            ref_mem[a[4:0]] = dout_want;
        end
        exp_q.push_back(e);
        sel = 1'b1; io_rd = rd; io_wr = !rd; io_a = a; io_be = be; io_di = di;
        @(posedge clk);
        @(negedge clk);
        chk("ram_addr", ram_addr, a);
        sel = 1'b0; io_rd = 1'b0; io_wr = 1'b0; io_di = $urandom; io_be = 4'($urandom);
        for (int k = 0; k < 22; k++) begin
            if (!ram_oe) oe_n++;
            if (!ram_wr) begin
                wr_n++;
                dout_seen = ram_dout;
                if (!ram_doe) doe_bad++;
            end
            @(negedge clk);
        end
        chk("oe_low_cycles", 32'(oe_n), 32'(oe_want));
        chk("wr_low_cycles", 32'(wr_n), 32'(wr_want));
        chk("doe_during_wr", 32'(doe_bad), 32'd0);
        if (!rd) chk("ram_dout", dout_seen, dout_want);
    endtask

    task automatic lat2(input bit rd, input logic [3:0] be, input int want);
        int e0, got;
        e0 = cyc + 1; got = -1;
        sel2 = 1'b1; rd2 = rd; wr2 = !rd; a2 = 19'h00042; be2 = be; di2 = 32'hCAFEF00D;
        for (int k = 0; k < 40 && got < 0; k++) begin
            @(negedge clk);
            if (k == 0) begin sel2 = 1'b0; rd2 = 1'b0; wr2 = 1'b0; end
            if (ready2) got = cyc - e0;
        end
        chk(rd ? "lat2_read" : "lat2_rmw", 32'(got), 32'(want));
        if (rd) chk("q2_read", q2, din2);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] dseen;
        rst_b = 1'b0; sel = 1'b0; io_rd = 1'b0; io_wr = 1'b0; io_a = '0; io_be = '0; io_di = '0;
        sel2 = 1'b0; rd2 = 1'b0; wr2 = 1'b0; a2 = '0; be2 = '0; di2 = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;

        fork
            begin : monitor
                logic        prev_ready;
                logic [31:0] prev_q;
                exp_t        e;
                prev_ready = 1'b0; prev_q = '0;
                forever begin
                    @(negedge clk);
                    if (rst_b) begin
                        if (io_ready) begin
                            chk("ready_single_cycle", 32'(prev_ready), 32'd0);
                            if (exp_q.size() == 0) begin
                                chk("unexpected_ready", 32'd1, 32'd0);
                            end else begin
                                e = exp_q.pop_front();
                                chk("ready_latency", 32'(cyc - e.e0), 32'(e.lat));
                                if (e.is_rd) chk("io_q", io_q, e.data);
                            end
                        end
                        if (io_q !== prev_q) chk("io_q_change_w/o_ready", 32'(io_ready), 32'd1);
                    end
                    prev_ready = io_ready;
                    prev_q     = io_q;
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_io_ready", 32'(io_ready), 32'd0);
        chk("rst_io_q", io_q, 32'd0);
        chk("rst_strobes", {29'd0, ram_cs, ram_oe, ram_wr}, 32'd7);
        chk("rst_lanes", {30'd0, ram_ub_b, ram_lb_b}, 32'd3);
        chk("rst_doe", 32'(ram_doe), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_dout", ram_dout, 32'd0);
        rst_b = 1'b1;
        @(negedge clk);
        chk("idle_strobes", {28'd0, ram_cs, ram_oe, ram_wr, ram_doe}, 32'hE);

        txn(1'b0, 19'h00003, 4'hF, 32'h12345678, dseen);
        txn(1'b0, 19'h00010, 4'hF, 32'hDEADBEEF, dseen);
        txn(1'b1, 19'h00010, 4'h0, 32'h0, dseen);
        txn(1'b0, 19'h00005, 4'hF, 32'h11223344, dseen);
        txn(1'b0, 19'h00005, 4'b0010, 32'hAABBCCDD, dseen);
        chk("partial_merge_const", dseen, 32'h1122CC44);
        txn(1'b1, 19'h00005, 4'h0, 32'h0, dseen);

        // Read held through DONE: the second accept can only happen from IDLE.
        begin
            exp_t e;
            e.is_rd = 1'b1; e.data = ref_mem[3]; e.e0 = cyc + 1; e.lat = RD + 1;
            exp_q.push_back(e);
            e.e0 = cyc + 1 + RD + 3;
            exp_q.push_back(e);
            sel = 1'b1; io_rd = 1'b1; io_wr = 1'b1; io_a = 19'h00003; io_be = 4'hF; io_di = 32'h0;
            repeat (RD + 4) @(posedge clk);
            @(negedge clk);
            sel = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
            repeat (20) @(negedge clk);
        end

        for (int t = 0; t < 60; t++) begin
            logic [3:0] be;
            be = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            txn($urandom_range(0, 2) == 0, {14'($urandom), 5'($urandom)}, be, $urandom, dseen);
        end

        for (int i = 0; i < 32; i++) chk("sram_contents", mem[i], ref_mem[i]);

        // Reset while the write strobe is active.
        begin
            exp_t e;
`ifdef POSTED_WRITE_EN
            e.is_rd = 1'b0; e.data = '0; e.e0 = cyc + 1; e.lat = 1;
            exp_q.push_back(e);
`endif
            sel = 1'b1; io_wr = 1'b1; io_a = 19'h00007; io_be = 4'hF; io_di = 32'h0BADF00D;
            @(posedge clk);
            @(negedge clk);
            sel = 1'b0; io_wr = 1'b0;
            chk("pre_rst_wr_low", 32'(ram_wr), 32'd0);
            rst_b = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("rst_mid_wr", 32'(ram_wr), 32'd1);
            chk("rst_mid_doe", 32'(ram_doe), 32'd0);
            chk("rst_mid_ready", 32'(io_ready), 32'd0);
            chk("rst_mid_cs", 32'(ram_cs), 32'd1);
            chk("rst_mid_state", 32'(dut.state), 32'(IDLE));
            for (int i = 0; i < 32; i++) ref_mem[i] = '0;
            rst_b = 1'b1;
            repeat (3) @(negedge clk);
        end

        lat2(1'b1, 4'h0, 1);
        lat2(1'b0, 4'b0101, 16);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_bus_ctrl.md
SRAM_BUS_CTRL -- requirements
Module: sram_bus_ctrl

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1: extra wait cycles for a read (0..7).
REQ-002 SHALL have parameter WR_LATENCY, default 1: extra wait cycles for a full-word write (0..7).
REQ-003 SHALL have parameter RMW_RD_LATENCY, default 1: extra wait cycles for the read phase of a read-modify-write (0..7).
REQ-004 SHALL have parameter RMW_WR_LATENCY, default 1: extra wait cycles for the write phase of a read-modify-write (0..7).
REQ-005 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  the only clock; everything samples on its rising edge.
- rst_b  in  1  reset, synchronous and active-low.
- sel  in  1  RAM region decode from the CPU bus.
- io_rd  in  1  CPU read strobe.
- io_wr  in  1  CPU write strobe.
- io_a  in  19  word address, CPU address bits 20:2.
- io_be  in  4  byte enables; bit n covers io_di[8n+7:8n].
- io_di  in  32  CPU write data.
- io_q  out  32  registered read data.
- io_ready  out  1  one-cycle completion pulse to the CPU.
- ram_cs, ram_oe, ram_wr  out  1 each  SRAM strobes, all active low.
- ram_ub_b, ram_lb_b  out  1 each  SRAM byte-lane enables, active low.
- ram_addr  out  19  SRAM word address.
- ram_dout  out  32  SRAM write data.
- ram_doe  out  1  output enable for the tristate buffer on the SRAM data bus.
- ram_din  in  32  SRAM read data.

Function
REQ-006 SHALL implement five states: IDLE, READ, RMW_RD, WRITE and DONE; it SHALL be in IDLE after reset.
REQ-007 In IDLE, when sel&io_rd is high at edge E0: SHALL go to READ, drive cs=0, oe=0, wr=1, ub_b=lb_b=0, ram_addr=io_a, doe=0, and load the counter with RD_LATENCY.
REQ-008 In IDLE, when sel&io_wr is high and io_be=4'b1111 at E0: SHALL go to WRITE, drive cs=0, oe=1, wr=0, ram_dout=io_di, doe=1, and load the counter with WR_LATENCY.
REQ-009 In IDLE, when sel&io_wr is high and io_be!=4'b1111 at E0: SHALL go to RMW_RD, drive the read strobes as in REQ-007, and load the counter with RMW_RD_LATENCY.
REQ-010 If io_rd and io_wr are both high at E0, SHALL give the read priority.
REQ-011 In IDLE with no request: cs, oe and wr SHALL be 1 and doe SHALL be 0.
REQ-012 In READ, RMW_RD and WRITE, a nonzero counter SHALL decrement and the state SHALL hold.
REQ-013 READ with counter 0: SHALL register io_q<=ram_din, set all strobes high, set io_ready=1 and go to DONE; io_ready therefore rises after edge E0+RD_LATENCY+1.
REQ-014 RMW_RD with counter 0: SHALL drive ram_dout = per-byte merge (io_be[n] ? io_di lane : ram_din lane), drive cs=0, oe=1, wr=0, doe=1, load RMW_WR_LATENCY and go to WRITE.
REQ-015 WRITE with counter 0: SHALL set all strobes high, set doe=0 and go to DONE; io_ready=1 in this cycle unless REQ-021 applies.
REQ-016 In DONE: SHALL set io_ready=0 and go to IDLE; a request present in DONE SHALL NOT be accepted until IDLE.
REQ-017 io_ready SHALL never be high for more than one consecutive cycle.
REQ-018 io_q SHALL change only on a read completion.
REQ-019 A request dropped before completion SHALL still complete its SRAM cycle.

Reset
REQ-020 While rst_b=0 at an edge, the block SHALL set:
- state=IDLE, counter=0
- io_ready=0, io_q=0
- cs=oe=wr=1, ub_b=lb_b=1
- doe=0, ram_addr=0, ram_dout=0
This holds even when a cycle is in flight.

Configuration
REQ-021 With POSTED_WRITE_EN defined:
- a full-word write SHALL pulse io_ready at entry to WRITE, i.e. after E0.
- completion of that write SHALL NOT pulse io_ready again.
- read-modify-write timing is unchanged.
REQ-022 Without POSTED_WRITE_EN, every write SHALL acknowledge per REQ-015.

Structure
REQ-023 Package sram_bus_ctrl_pkg SHALL hold the state enum and the default latency constants.
REQ-024 The byte-lane merge SHALL be a combinational sub-module, sram_be_merge.

Verification
REQ-025 Read, RD_LATENCY=1, io_a=19'h00010, ram_din=32'hDEADBEEF -> io_ready high exactly after E0+2, io_q=32'hDEADBEEF, oe low for 2 cycles.
REQ-026 Full write, io_be=4'hF, io_di=32'h12345678 -> wr low for WR_LATENCY+1 cycles, ram_dout=32'h12345678, doe=1; io_ready after E0+2, or after E0+1 with POSTED_WRITE_EN.
REQ-027 Partial write, io_be=4'b0010, io_di=32'hAABBCCDD, ram_din=32'h11223344 -> write phase drives ram_dout=32'h1122CC44, io_ready after E0+4.
REQ-028 Back-to-back reads held high through DONE -> second cycle starts only from IDLE, io_ready pulses are separated by at least one low cycle.
REQ-029 rst_b=0 during WRITE with wr=0 -> next edge gives wr=1, doe=0, io_ready=0, state IDLE.
REQ-030 RD_LATENCY=0 and RMW latencies=7 -> read ready after E0+1, partial write ready after E0+16.
